// File: rtl/spi_pkg.sv
// Shared definitions for the debug-link SPI master and slave.
// Holds the controller FSM encoding, the minimum CS timing constants and the SPI mode.
// Also provides a small ceiling-log2 helper for sizing counters.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

    // The slave needs one cycle to load its word before the first SCLK edge,
    // and capture plus finish after the falling edge.
    localparam int MIN_CS_SETUP = 2;
    localparam int MIN_CS_HOLD  = 2;

    // Mode 0: SCLK idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_master_parallel_ctrl_if.sv
// Host and SPI-side signals of the parallel SPI master.
// Ports: i_start/i_tx_data (host request), o_rx_data/o_valid/o_busy (host result),
//        o_MOSI/o_SCLK/o_cs (to slave), i_MISO (from slave).
interface spi_master_parallel_ctrl_if #(
    parameter int NB_BITS = 32
);
    logic               i_start;
    logic [NB_BITS-1:0] i_tx_data;
    logic [NB_BITS-1:0] i_MISO;
    logic [NB_BITS-1:0] o_MOSI;
    logic               o_SCLK;
    logic               o_cs;
    logic [NB_BITS-1:0] o_rx_data;
    logic               o_valid;
    logic               o_busy;

    // The controller side.
    modport master (
        input  i_start, i_tx_data, i_MISO,
        output o_MOSI, o_SCLK, o_cs, o_rx_data, o_valid, o_busy
    );

    // The host / slave side that drives requests and MISO.
    modport slave (
        output i_start, i_tx_data, i_MISO,
        input  o_MOSI, o_SCLK, o_cs, o_rx_data, o_valid, o_busy
    );
endinterface

// File: rtl/spi_phase_counter.sv
// Loadable down-counter timing each phase of an SPI transaction.
// Ports: load/load_val set the count, dec decrements (saturating at 0), zero flags count==0.
// Load takes priority over decrement; synchronous active-high reset clears to 0.
module spi_phase_counter #(
    parameter int NB_CNT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              load,
    input  logic [NB_CNT-1:0] load_val,
    input  logic              dec,
    output logic              zero
);
    logic [NB_CNT-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/spi_master_parallel_ctrl.sv
// Parallel-word SPI master (mode 0): one NB_BITS word each way per CS frame.
// Ports: i_clk, i_rst (sync, active-high), bus (master modport of spi_master_parallel_ctrl_if).
// Timing from accepted i_start at cycle 0: CS 1..CS_SETUP+CLK_DIV+CS_HOLD, o_valid the cycle after.
// Build option SPI_MASTER_LOOPBACK_EN: rx sample takes o_MOSI instead of i_MISO.
module spi_master_parallel_ctrl
    import spi_pkg::*;
#(
    parameter int NB_BITS  = 32,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int NB_CNT   = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    spi_master_parallel_ctrl_if.master bus
);
    localparam logic [NB_CNT-1:0] SETUP_LD = NB_CNT'(CS_SETUP - 1);
    localparam logic [NB_CNT-1:0] HIGH_LD  = NB_CNT'(CLK_DIV - 1);
    localparam logic [NB_CNT-1:0] HOLD_LD  = NB_CNT'(CS_HOLD - 1);

    spi_state_t         state_q, state_d;
    logic [NB_BITS-1:0] mosi_q, mosi_d;
    logic [NB_BITS-1:0] rx_q, rx_d;
    logic [NB_BITS-1:0] rx_out_q, rx_out_d;
    logic               sclk_q, sclk_d;
    logic               cs_q, cs_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [NB_CNT-1:0]  cnt_val;
    logic [NB_BITS-1:0] sample;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample = mosi_q;
`else
    assign sample = bus.i_MISO;
`endif

    spi_phase_counter #(.NB_CNT(NB_CNT)) u_phase_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            mosi_q   <= '0;
            rx_q     <= '0;
            rx_out_q <= '0;
            sclk_q   <= 1'b0;
            cs_q     <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mosi_q   <= mosi_d;
            rx_q     <= rx_d;
            rx_out_q <= rx_out_d;
            sclk_q   <= sclk_d;
            cs_q     <= cs_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    // Outputs are computed one cycle ahead so every pin comes straight from a flop;
    // SCLK and CS edges therefore always land in different cycles.
    always_comb begin
        state_d  = state_q;
        mosi_d   = mosi_q;
        rx_d     = rx_q;
        rx_out_d = rx_out_q;
        sclk_d   = sclk_q;
        cs_d     = cs_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    mosi_d   = bus.i_tx_data;
                    cs_d     = 1'b1;
                    busy_d   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = SETUP_LD;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    sclk_d   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = HIGH_LD;
                    state_d  = ST_HIGH;
                end else begin
                    cnt_dec  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_zero) begin
                    // Last high cycle: the slave's word has been stable since setup.
                    rx_d     = sample;
                    sclk_d   = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LD;
                    state_d  = ST_HOLD;
                end else begin
                    cnt_dec  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    cs_d     = 1'b0;
                    rx_out_d = rx_q;
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_dec  = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_MOSI    = mosi_q;
    assign bus.o_SCLK    = sclk_q;
    assign bus.o_cs      = cs_q;
    assign bus.o_rx_data = rx_out_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_busy    = busy_q;
endmodule

// File: doc/spi_master_parallel_ctrl.md
Name: spi_master_parallel_ctrl

Overview:
- Parallel-bus SPI master (CPOL=0, CPHA=0) that drives the debug SPI slave link of the MIPS board: generates active-high CS, SCLK and the NB_BITS-wide MOSI word.
- Samples the slave's NB_BITS-wide MISO word and returns it to the host-side logic (debug unit or UART bridge) with a start/valid handshake.
- Exactly one word is exchanged in each direction per transaction.

Parameters:
- NB_BITS, 32, width of the MOSI/MISO/data words.
- CLK_DIV, 4, i_clk cycles SCLK stays high. Legal range ≥1.
- CS_SETUP, 2, i_clk cycles CS is high with SCLK low before the rising SCLK edge. Legal range ≥2, because the slave needs one cycle to load its word.
- CS_HOLD, 2, i_clk cycles CS stays high after the falling SCLK edge. Legal range ≥2, because the slave needs capture plus finish.
- NB_CNT, 8, width of the internal phase counter. Must hold max(CLK_DIV, CS_SETUP, CS_HOLD).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous, active-high reset
- i_start  input  1  request a transaction; sampled only in IDLE
- i_tx_data  input  NB_BITS  word to send; latched on an accepted i_start
- i_MISO  input  NB_BITS  word driven by the slave while CS is high
- o_MOSI  output  NB_BITS  registered transmit word
- o_SCLK  output  1  registered serial clock
- o_cs  output  1  registered chip select, active-high
- o_rx_data  output  NB_BITS  last received word; holds until the next completion
- o_valid  output  1  one-cycle pulse when o_rx_data is updated
- o_busy  output  1  high from cycle 1 of a transaction through DONE

Behaviour:
- Reset: every output is 0, state is IDLE, counter is 0. Reset mid-transaction behaves the same: CS and SCLK drop on the next edge and no o_valid is generated.
- All outputs are registered, with no combinational path from input to output.
- FSM states: IDLE, SETUP, HIGH, HOLD, DONE.
- IDLE: when i_start=1, latch i_tx_data into o_MOSI, set o_cs=1 and o_busy=1, load counter with CS_SETUP-1, go to SETUP. When i_start=0, hold all outputs.
- SETUP: o_SCLK=0. When counter==0, set o_SCLK=1, load CLK_DIV-1, go to HIGH. Otherwise decrement.
- HIGH: o_SCLK=1. When counter==0, sample i_MISO into the internal rx register (this is the last high cycle), set o_SCLK=0, load CS_HOLD-1, go to HOLD. Otherwise decrement.
- HOLD: o_cs=1, o_SCLK=0, o_MOSI stable; the slave captures on the falling edge during this phase. When counter==0, set o_cs=0, copy rx into o_rx_data, set o_valid=1, go to DONE.
- DONE: o_cs=0, o_valid=1 for this single cycle, o_busy deasserts at the end of the cycle. Always go to IDLE.
- Timing: with i_start accepted at cycle 0, CS is high for cycles 1..CS_SETUP+CLK_DIV+CS_HOLD. o_valid is high in the following cycle. With defaults, CS spans cycles 1-8, SCLK is high in cycles 3-6, o_valid is in cycle 9, and the earliest next accept is cycle 10.
- CS is always low for at least 2 cycles (DONE + IDLE) between transactions, so the slave returns to its idle state.
- o_MOSI keeps its last value after the transaction and is not cleared.
- i_start while busy is ignored, with no queuing.
- SCLK never rises while CS is low, and CS never changes in the same cycle as an SCLK edge.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined: i_MISO is ignored and the HIGH-phase sample takes o_MOSI, so o_rx_data equals the transmitted word. All bus timing is unchanged, and this is used for board bring-up without a slave.
- Undefined: i_MISO is sampled as specified in Behaviour.

Decomposition:
- Package spi_pkg:
  - state encodings for IDLE, SETUP, HIGH, HOLD, DONE
  - the clog2 function
  - minimum-timing constants MIN_CS_SETUP=2 and MIN_CS_HOLD=2
  - CPOL/CPHA mode constants shared with the slave
- One sub-module, spi_phase_counter: a loadable down-counter with load, value and zero flag, NB_CNT wide.

Test Plan:
- Reset with i_start=1 held high → all outputs 0 and no transaction until reset drops; i_start is then accepted on the first cycle after reset.
- Defaults, i_tx_data=32'hDEADBEEF, bench slave model returning 32'h12345678 → o_cs high cycles 1-8, o_SCLK high cycles 3-6, o_MOSI=DEADBEEF from cycle 1, o_valid pulses at cycle 9 with o_rx_data=12345678.
- i_start pulsed at cycles 3 and 9 during a busy transaction → both ignored; only one o_valid. A new i_start at cycle 10 starts a second transaction with CS rising at cycle 11.
- Back-to-back with i_start held high and payloads A5A5A5A5 then 5A5A5A5A → CS low for exactly 2 cycles between transactions, slave model captures each word on its falling SCLK edge, and two o_valid pulses arrive 10 cycles apart.
- i_rst asserted at cycle 5 (mid-HIGH) → o_cs=0, o_SCLK=0 and o_busy=0 at cycle 6; no o_valid; o_rx_data=0.
- SPI_MASTER_LOOPBACK_EN defined, i_tx_data=32'h0F0F0F0F, i_MISO=32'hFFFFFFFF → o_rx_data=0F0F0F0F with the same cycle timing as the default case.
